// File: rtl/d_kes_pe_dc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : d_kes_pe_dc_ctrl_pkg
// Purpose : Shared constants, state encoding and GF(2^12) multiply helper for
//           the KES discrepancy-computation / iteration-control stage.
// Revision: 1.0 - initial release
// ============================================================================
package d_kes_pe_dc_ctrl_pkg;

  // Symbol width of the field this stage is built for.
  localparam int D_KES_GF_ORDER = 12;

  localparam logic [D_KES_GF_ORDER-1:0] VALUE_ZERO = 12'h000;
  localparam logic [D_KES_GF_ORDER-1:0] VALUE_ONE  = 12'h001;

  // Field polynomial x^12 + x^6 + x^4 + x + 1; the x^12 term is implicit.
  localparam logic [D_KES_GF_ORDER-1:0] GF_POLY_LOW = 12'h053;

  // One-hot controller states.
  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_ACC  = 6'b000010,
    ST_COND = 6'b000100,
    ST_EXEC = 6'b001000,
    ST_WAIT = 6'b010000,
    ST_DONE = 6'b100000
  } kes_state_t;

  // Shift-and-add GF(2^12) multiply: walk the bits of b while repeatedly
  // multiplying a by x with on-the-fly reduction.
  function automatic logic [D_KES_GF_ORDER-1:0] gf_mul(
    input logic [D_KES_GF_ORDER-1:0] a,
    input logic [D_KES_GF_ORDER-1:0] b
  );
    logic [D_KES_GF_ORDER-1:0] acc;
    logic [D_KES_GF_ORDER-1:0] x;
    acc = VALUE_ZERO;
    x   = a;
    for (int i = 0; i < D_KES_GF_ORDER; i++) begin
      if (b[i]) acc = acc ^ x;
      if (x[D_KES_GF_ORDER-1]) x = {x[D_KES_GF_ORDER-2:0], 1'b0} ^ GF_POLY_LOW;
      else                     x = {x[D_KES_GF_ORDER-2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/d_kes_pe_dc_ctrl_gfmul.sv
`default_nettype none
// ============================================================================
// Module  : d_kes_pe_dc_ctrl_gfmul
// Purpose : Combinational GF(2^12) multiplier forming syndrome x coefficient.
// Revision: 1.0 - initial release
// ============================================================================
module d_kes_pe_dc_ctrl_gfmul
  import d_kes_pe_dc_ctrl_pkg::*;
(
  input  logic [D_KES_GF_ORDER-1:0] a,
  input  logic [D_KES_GF_ORDER-1:0] b,
  output logic [D_KES_GF_ORDER-1:0] p
);

  // Pure product; no state.
  always_comb begin
    p = gf_mul(a, b);
  end

endmodule
`default_nettype wire

// File: rtl/d_kes_pe_dc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : d_kes_pe_dc_ctrl
// Purpose : Discrepancy accumulation and iteration control for the
//           inversionless Berlekamp-Massey KES (binary BCH). Accumulates d_2i
//           from serial (syndrome, v) pairs, derives condition_2i, strobes the
//           ELU PE array once per iteration and flags completion after ECC_T
//           iterations.
// Revision: 1.0 - initial release
// ============================================================================
module d_kes_pe_dc_ctrl
  import d_kes_pe_dc_ctrl_pkg::*;
#(
  parameter int GF_ORDER = 12,
  parameter int ECC_T    = 14,
  parameter int K_WIDTH  = 6
) (
  input  logic                i_clk,
  input  logic                i_RESET_KES,
  input  logic                i_stop_dec,
  input  logic                i_execute_kes,
  input  logic                i_term_valid,
  input  logic                i_term_last,
  input  logic [GF_ORDER-1:0] i_syndrome,
  input  logic [GF_ORDER-1:0] i_v_coef,
  output logic                o_term_ready,
  output logic [GF_ORDER-1:0] o_d_2i,
  output logic [GF_ORDER-1:0] o_delta_2im2,
  output logic                o_condition_2i,
  output logic                o_EXECUTE_PE_ELU,
  output logic [3:0]          o_iter_cnt,
  output logic                o_busy,
  output logic                o_kes_done,
  output logic                o_term_err
);

  // Term counter must reach ECC_T (index of the (ECC_T+1)-th term).
  localparam int TC_W = $clog2(ECC_T + 2);

  kes_state_t                 state;
  logic [GF_ORDER-1:0]        d;
  logic [GF_ORDER-1:0]        delta;
  logic signed [K_WIDTH-1:0]  k;
  logic [3:0]                 iter;
  logic [TC_W-1:0]            term_cnt;
  logic                       condition;
  logic                       term_err;
  logic [GF_ORDER-1:0]        prod;
  logic                       abort;
  logic                       transfer;
  logic                       last_term;

  d_kes_pe_dc_ctrl_gfmul u_gfmul (
    .a (i_syndrome),
    .b (i_v_coef),
    .p (prod)
  );

  assign abort     = i_RESET_KES | i_stop_dec;
  assign transfer  = i_term_valid & (state == ST_ACC);
  // A full iteration's worth of terms closes the iteration even without last.
  assign last_term = i_term_last | (term_cnt == TC_W'(ECC_T));

  // Controller FSM with accumulator, delta, k, iteration and term counters.
  always_ff @(posedge i_clk) begin
    if (abort) begin
      state     <= ST_IDLE;
      d         <= VALUE_ZERO;
      delta     <= VALUE_ONE;
      k         <= '0;
      iter      <= '0;
      term_cnt  <= '0;
      condition <= 1'b0;
      term_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_execute_kes) begin
            state    <= ST_ACC;
            d        <= VALUE_ZERO;
            delta    <= VALUE_ONE;
            k        <= '0;
            iter     <= '0;
            term_cnt <= '0;
          end
        end
        ST_ACC: begin
          if (transfer) begin
            d        <= d ^ prod;
            term_cnt <= term_cnt + 1'b1;
            if (last_term) begin
              state <= ST_COND;
              if (!i_term_last) term_err <= 1'b1;
            end
          end
        end
        ST_COND: begin
          condition <= (|d) & ~k[K_WIDTH-1];
          state     <= ST_EXEC;
        end
        ST_EXEC: begin
          // ELU samples d/delta/condition at this edge; update after.
          if (condition) begin
            delta <= d;
            k     <= ~k;  // -k-1 in two's complement
          end else begin
            k     <= k + K_WIDTH'(1);
          end
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (iter == 4'(ECC_T - 1)) begin
            state <= ST_DONE;
          end else begin
            iter     <= iter + 4'd1;
            d        <= VALUE_ZERO;
            term_cnt <= '0;
            state    <= ST_ACC;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes are state decodes, suppressed in a cycle where reset/stop wins.
  assign o_EXECUTE_PE_ELU = (state == ST_EXEC) & ~abort;
  assign o_kes_done       = (state == ST_DONE) & ~abort;
  assign o_term_ready     = (state == ST_ACC);
  assign o_busy           = (state != ST_IDLE);
  assign o_d_2i           = d;
  assign o_delta_2im2     = delta;
  assign o_condition_2i   = condition;
  assign o_iter_cnt       = iter;
  assign o_term_err       = term_err;

endmodule
`default_nettype wire

// File: tb/tb_d_kes_pe_dc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_d_kes_pe_dc_ctrl
// Purpose : Self-checking bench for d_kes_pe_dc_ctrl with a behavioural
//           Berlekamp-Massey discrepancy/iteration model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_d_kes_pe_dc_ctrl;

  localparam int GF = 12;
  localparam int T  = 14;

  logic          clk;
  logic          rst, stop, exec_in, valid, last;
  logic [GF-1:0] syn, vc;
  logic          term_ready, cond_o, exec_o, busy, done, term_err;
  logic [GF-1:0] d_o, delta_o;
  logic [3:0]    iter_o;

  int checks = 0;
  int errors = 0;
  int exec_cnt = 0;
  int done_cnt = 0;

  // Behavioural model state.
  int            k_m;
  int            iter_m;
  logic [GF-1:0] delta_m;
  logic [GF-1:0] part_m;
  bit            cmp_mode;

  logic [GF-1:0] rec_s [T][15];
  logic [GF-1:0] rec_v [T][15];
  int            rec_n [T];
  logic [GF-1:0] rec_d [T];

  d_kes_pe_dc_ctrl #(.GF_ORDER(GF), .ECC_T(T), .K_WIDTH(6)) dut (
    .i_clk            (clk),
    .i_RESET_KES      (rst),
    .i_stop_dec       (stop),
    .i_execute_kes    (exec_in),
    .i_term_valid     (valid),
    .i_term_last      (last),
    .i_syndrome       (syn),
    .i_v_coef         (vc),
    .o_term_ready     (term_ready),
    .o_d_2i           (d_o),
    .o_delta_2im2     (delta_o),
    .o_condition_2i   (cond_o),
    .o_EXECUTE_PE_ELU (exec_o),
    .o_iter_cnt       (iter_o),
    .o_busy           (busy),
    .o_kes_done       (done),
    .o_term_err       (term_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters sampled at the active edge.
  always @(posedge clk) begin
    if (exec_o) exec_cnt <= exec_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end

  // Carry-less product then long division by x^12+x^6+x^4+x+1.
  function automatic logic [GF-1:0] ref_mul(input logic [GF-1:0] a, input logic [GF-1:0] b);
    logic [22:0] p;
    logic [22:0] poly;
    p = '0;
    for (int i = 0; i < GF; i++)
      if (b[i]) p = p ^ (23'(a) << i);
    for (int bt = 22; bt >= GF; bt--) begin
      poly = 23'h1053 << (bt - GF);
      if (p[bt]) p = p ^ poly;
    end
    return p[GF-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_d"}, 32'(d_o), 32'h000);
    chk({tag, "_delta"}, 32'(delta_o), 32'h001);
    chk({tag, "_cond"}, 32'(cond_o), 32'd0);
    chk({tag, "_exec"}, 32'(exec_o), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(term_ready), 32'd0);
    chk({tag, "_iter"}, 32'(iter_o), 32'd0);
    chk({tag, "_err"}, 32'(term_err), 32'd0);
  endtask

  task automatic start_kes();
    exec_in = 1'b1;
    @(negedge clk);
    exec_in = 1'b0;
    k_m = 0; delta_m = 12'h001; part_m = '0; iter_m = 0;
    chk("start_ready", 32'(term_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_iter", 32'(iter_o), 32'd0);
    chk("start_d", 32'(d_o), 32'h000);
  endtask

  // One accepted term, optionally preceded by an idle (valid low) cycle.
  task automatic feed(input logic [GF-1:0] s, input logic [GF-1:0] v,
                      input bit is_last, input bit gap);
    if (gap) begin
      valid = 1'b0;
      syn   = GF'($urandom);
      vc    = GF'($urandom);
      last  = 1'($urandom);
      @(negedge clk);
      chk("gap_hold_d", 32'(d_o), 32'(part_m));
    end
    chk("feed_ready", 32'(term_ready), 32'd1);
    valid = 1'b1; syn = s; vc = v; last = is_last;
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    part_m = part_m ^ ref_mul(s, v);
    chk("acc_d", 32'(d_o), 32'(part_m));
  endtask

  // Walk COND, EXEC, WAIT and the following ACC/DONE cycle of one iteration.
  task automatic finish_iter();
    bit exp_cond;
    chk("cond_noexec", 32'(exec_o), 32'd0);
    chk("cond_notready", 32'(term_ready), 32'd0);
    @(negedge clk);
    exp_cond = (part_m != '0) && (k_m >= 0);
    chk("exec_pulse", 32'(exec_o), 32'd1);
    chk("exec_d", 32'(d_o), 32'(part_m));
    chk("exec_delta", 32'(delta_o), 32'(delta_m));
    chk("exec_cond", 32'(cond_o), 32'(exp_cond));
    chk("exec_iter", 32'(iter_o), 32'(iter_m));
    if (cmp_mode) chk("gapless_equal_d", 32'(d_o), 32'(rec_d[iter_m]));
    else          rec_d[iter_m] = part_m;
    if (exp_cond) begin
      delta_m = part_m;
      k_m     = -k_m - 1;
    end else begin
      k_m     = k_m + 1;
    end
    @(negedge clk);
    chk("wait_noexec", 32'(exec_o), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    @(negedge clk);
    if (iter_m == T - 1) begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_hold_d", 32'(d_o), 32'(part_m));
      chk("done_hold_delta", 32'(delta_o), 32'(delta_m));
      chk("done_hold_cond", 32'(cond_o), 32'(exp_cond));
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end else begin
      iter_m++;
      part_m = '0;
      chk("next_ready", 32'(term_ready), 32'd1);
      chk("next_iter", 32'(iter_o), 32'(iter_m));
      chk("next_d_clear", 32'(d_o), 32'h000);
      chk("next_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int e0, dn0;
    rst = 1'b1; stop = 1'b0; exec_in = 1'b0; valid = 1'b0; last = 1'b0;
    syn = '0; vc = '0; cmp_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    // Codeword A: directed first two iterations, then random, no gaps.
    start_kes();
    e0 = exec_cnt; dn0 = done_cnt;
    rec_n[0] = 1; rec_s[0][0] = 12'h123; rec_v[0][0] = 12'h001;
    feed(12'h123, 12'h001, 1'b1, 1'b0);
    finish_iter();
    rec_n[1] = 1; rec_s[1][0] = 12'h000; rec_v[1][0] = GF'($urandom);
    feed(rec_s[1][0], rec_v[1][0], 1'b1, 1'b0);
    finish_iter();
    for (int it = 2; it < T; it++) begin
      rec_n[it] = int'($urandom_range(1, 15));
      for (int t = 0; t < rec_n[it]; t++) begin
        rec_s[it][t] = GF'($urandom);
        rec_v[it][t] = GF'($urandom);
        exec_in = (it == 4);
        feed(rec_s[it][t], rec_v[it][t], t == rec_n[it] - 1, 1'b0);
      end
      exec_in = 1'b0;
      finish_iter();
    end
    chk("run_exec_count", 32'(exec_cnt - e0), 32'd14);
    chk("run_done_count", 32'(done_cnt - dn0), 32'd1);
    chk("run_no_err", 32'(term_err), 32'd0);

    // Codeword B: same terms with random valid gaps.
    cmp_mode = 1'b1;
    start_kes();
    for (int it = 0; it < T; it++) begin
      for (int t = 0; t < rec_n[it]; t++)
        feed(rec_s[it][t], rec_v[it][t], t == rec_n[it] - 1, 1'($urandom_range(0, 1)));
      finish_iter();
    end
    cmp_mode = 1'b0;

    // Codeword C: 15 terms without last, then stop during ACC.
    start_kes();
    for (int t = 0; t < 15; t++)
      feed(GF'($urandom), GF'($urandom), 1'b0, 1'b0);
    finish_iter();
    chk("term_err_set", 32'(term_err), 32'd1);
    feed(GF'($urandom), GF'($urandom), 1'b0, 1'b0);
    feed(GF'($urandom), GF'($urandom), 1'b0, 1'b0);
    chk("term_err_sticky", 32'(term_err), 32'd1);
    dn0 = done_cnt;
    stop = 1'b1; valid = 1'b1; syn = GF'($urandom); vc = GF'($urandom);
    @(negedge clk);
    stop = 1'b0; valid = 1'b0;
    check_reset("stop_acc");
    chk("stop_acc_no_done", 32'(done_cnt - dn0), 32'd0);

    // Codeword D: stop while in EXEC.
    start_kes();
    feed(12'h0AB, 12'h0CD, 1'b1, 1'b0);
    @(negedge clk);
    e0 = exec_cnt; dn0 = done_cnt;
    stop = 1'b1;
    #1;
    chk("stop_exec_gate", 32'(exec_o), 32'd0);
    @(negedge clk);
    stop = 1'b0;
    check_reset("stop_exec");
    chk("stop_exec_no_pulse", 32'(exec_cnt - e0), 32'd0);
    chk("stop_exec_no_done", 32'(done_cnt - dn0), 32'd0);
    repeat (2) @(negedge clk);
    chk("stop_exec_stays_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
